// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension modes, output-stage states and width defaults shared by the immediate extender.
package imm_ext_pkg;
  localparam int IMM_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BR    = 2'b11
  } ext_mode_e;
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: grants the first valid request at or above ptr, wrapping past NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);
  logic [ID_W:0] cand;
  logic          hit;
  // One spare bit so ptr+i never overflows; the wrap is an explicit subtract, not a natural rollover.
  always_comb begin
    cand = '0;
    hit = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      cand = (cand >= (ID_W + 1)'(NREQ)) ? cand - (ID_W + 1)'(NREQ) : cand;
      if (!hit && req[cand[ID_W-1:0]]) begin
        hit = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end
  assign grant = hit ? (NREQ'(1) << grant_idx) : '0;
endmodule

// File: rtl/sign_extend.sv
// sign_extend: widens a two's-complement value by replicating its top bit.
module sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);
  assign out_o = {{(OUT_W - IN_W){in_i[IN_W-1]}}, in_i};
endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin shares one immediate extender among requesters behind a one-entry output stage.
// rsp_ready reaches req_ready combinationally; nothing on req_* reaches rsp_*.
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IMM_W-1:0] req_imm,
  input  logic [NREQ*2-1:0]     req_mode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [ID_W-1:0]       rsp_id
);
  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d, sext, ext;
  logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d, grant_idx;
  logic [NREQ-1:0]   grant;
  logic [IMM_W-1:0]  sel_imm;
  ext_mode_e         sel_mode;
  logic              can_accept, accept;
  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );
  assign sel_imm  = req_imm[int'(grant_idx) * IMM_W +: IMM_W];
  assign sel_mode = ext_mode_e'(req_mode[int'(grant_idx) * 2 +: 2]);
  sign_extend #(.IN_W(IMM_W), .OUT_W(DATA_W)) u_sext (
    .in_i (sel_imm),
    .out_o(sext)
  );
  assign ext = (sel_mode == EXT_ZERO)  ? DATA_W'(sel_imm) :
               (sel_mode == EXT_UPPER) ? DATA_W'(sel_imm) << (DATA_W - IMM_W) :
               (sel_mode == EXT_BR)    ? sext << 2 : sext;
  assign can_accept = (state_q == OUT_EMPTY) || rsp_ready;
  assign accept     = can_accept && |req_valid;
  assign req_ready  = can_accept ? grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  always_comb begin
    state_d = accept ? OUT_FULL : (rsp_ready ? OUT_EMPTY : state_q);
    data_d  = accept ? ext : data_q;
    id_d    = accept ? grant_idx : id_q;
    ptr_d   = !accept ? ptr_q : (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end
  always_comb begin
    rsp_valid = (state_q == OUT_FULL);
    rsp_data  = data_q;
    rsp_id    = id_q;
  end
endmodule
